// File: rtl/fetch_priv_ctrl.sv
// fetch_priv_ctrl: stalls, kills and redirects fetch around IBAR, CSR-write and TLB-op instructions.
module fetch_priv_ctrl #(
  parameter int SETTLE_CYC = 2,
  parameter int CNT_W      = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        flush,
  input  logic        dec_valid,
  input  logic        dec_ready,
  input  logic [31:0] dec_pc,
  input  logic [1:0]  ibar_flag,
  input  logic [1:0]  csr_flag,
  input  logic [1:0]  tlb_flag,
  input  logic        ibar_from_ex,
  input  logic        csr_from_ex,
  input  logic        tlb_from_ex,
  input  logic        icache_idle,
  input  logic        dcache_idle,
  input  logic        csr_done,
  input  logic        tlb_done,
  output logic        fetch_stall,
  output logic        flush_fetch,
  output logic        set_pc,
  output logic [31:0] pc_target,
  output logic [1:0]  priv_cause,
  output logic        busy
);
  typedef enum logic [3:0] {
    IDLE, WAIT_EX_IBAR, WAIT_EX_CSR, WAIT_EX_TLB,
    WAIT_CACHE_IDLE, WAIT_CSR_OK, WAIT_TLB_OK, SETTLE, REDIRECT
  } st_t;
  localparam int  SL  = (SETTLE_CYC > 0) ? SETTLE_CYC - 1 : 0;
  localparam st_t ADV = (SETTLE_CYC == 0) ? REDIRECT : SETTLE;
  st_t st, nxt;
  logic [CNT_W-1:0] cnt;
  logic [1:0] any;
  logic fire, cap;
  always_comb begin
    any  = ibar_flag | csr_flag | tlb_flag;
    fire = dec_valid & dec_ready & (|any);
    cap  = (st == IDLE) & fire & ~flush;
    nxt  = st;
    case (st)
      IDLE:            if (fire) nxt = |ibar_flag ? WAIT_EX_IBAR : |csr_flag ? WAIT_EX_CSR : WAIT_EX_TLB;
      WAIT_EX_IBAR:    if (ibar_from_ex) nxt = WAIT_CACHE_IDLE;
      WAIT_EX_CSR:     if (csr_from_ex) nxt = WAIT_CSR_OK;
      WAIT_EX_TLB:     if (tlb_from_ex) nxt = WAIT_TLB_OK;
      WAIT_CACHE_IDLE: if (icache_idle & dcache_idle) nxt = ADV;
      WAIT_CSR_OK:     if (csr_done) nxt = ADV;
      WAIT_TLB_OK:     if (tlb_done) nxt = ADV;
      SETTLE:          if (cnt == '0) nxt = REDIRECT;
      default:         nxt = IDLE;
    endcase
    if (flush) nxt = IDLE;
  end
  // outputs are registered from the next state so they line up with the state they describe
  always_ff @(posedge clk) begin
    if (rst) begin
      st          <= IDLE;
      cnt         <= '0;
      pc_target   <= '0;
      priv_cause  <= '0;
      fetch_stall <= 1'b0;
      flush_fetch <= 1'b0;
      set_pc      <= 1'b0;
      busy        <= 1'b0;
    end else begin
      st          <= nxt;
      cnt         <= flush ? '0 : (st != SETTLE && nxt == SETTLE) ? CNT_W'(SL) :
                     (st == SETTLE && cnt != '0) ? cnt - 1'b1 : cnt;
      if (cap) begin
        pc_target  <= dec_pc + (any[0] ? 32'd4 : 32'd8);
        priv_cause <= |ibar_flag ? 2'b01 : |csr_flag ? 2'b10 : 2'b11;
      end else if (nxt == IDLE) begin
        priv_cause <= 2'b00;
      end
      busy        <= nxt != IDLE;
      fetch_stall <= nxt != IDLE;
      flush_fetch <= nxt == WAIT_EX_IBAR || nxt == WAIT_EX_CSR || nxt == WAIT_EX_TLB;
      set_pc      <= nxt == REDIRECT;
    end
  end
endmodule

// File: tb/tb_fetch_priv_ctrl.sv
// tb_fetch_priv_ctrl: directed scoreboard bench for fetch_priv_ctrl (SETTLE_CYC=2 and 0 builds).
module tb_fetch_priv_ctrl;
  logic clk = 0, rst = 1, flush = 0, dec_valid = 0, dec_ready = 0;
  logic [31:0] dec_pc = 0;
  logic [1:0] ibar_flag = 0, csr_flag = 0, tlb_flag = 0;
  logic ibar_from_ex = 0, csr_from_ex = 0, tlb_from_ex = 0;
  logic icache_idle = 0, dcache_idle = 0, csr_done = 0, tlb_done = 0;
  logic fetch_stall, flush_fetch, set_pc, busy;
  logic [31:0] pc_target;
  logic [1:0] priv_cause;
  logic s0_stall, s0_flush, s0_set, s0_busy;
  logic [31:0] s0_pc;
  logic [1:0] s0_cause;
  typedef struct { logic [31:0] pc; logic [1:0] c; } exp_t;
  exp_t q[$];
  int checks = 0, failures = 0;
  always #5 clk = ~clk;
  fetch_priv_ctrl u (
    .clk(clk), .rst(rst), .flush(flush), .dec_valid(dec_valid), .dec_ready(dec_ready),
    .dec_pc(dec_pc), .ibar_flag(ibar_flag), .csr_flag(csr_flag), .tlb_flag(tlb_flag),
    .ibar_from_ex(ibar_from_ex), .csr_from_ex(csr_from_ex), .tlb_from_ex(tlb_from_ex),
    .icache_idle(icache_idle), .dcache_idle(dcache_idle), .csr_done(csr_done), .tlb_done(tlb_done),
    .fetch_stall(fetch_stall), .flush_fetch(flush_fetch), .set_pc(set_pc),
    .pc_target(pc_target), .priv_cause(priv_cause), .busy(busy));
  fetch_priv_ctrl #(.SETTLE_CYC(0)) u0 (
    .clk(clk), .rst(rst), .flush(flush), .dec_valid(dec_valid), .dec_ready(dec_ready),
    .dec_pc(dec_pc), .ibar_flag(ibar_flag), .csr_flag(csr_flag), .tlb_flag(tlb_flag),
    .ibar_from_ex(ibar_from_ex), .csr_from_ex(csr_from_ex), .tlb_from_ex(tlb_from_ex),
    .icache_idle(icache_idle), .dcache_idle(dcache_idle), .csr_done(csr_done), .tlb_done(tlb_done),
    .fetch_stall(s0_stall), .flush_fetch(s0_flush), .set_pc(s0_set),
    .pc_target(s0_pc), .priv_cause(s0_cause), .busy(s0_busy));
  task automatic chk(input string tag, input logic [31:0] o, input logic [31:0] e);
    checks++;
    assert (o === e) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, o, e);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
    {flush, dec_valid, dec_ready, ibar_flag, csr_flag, tlb_flag} = '0;
    {ibar_from_ex, csr_from_ex, tlb_from_ex, csr_done, tlb_done} = '0;
  endtask
  task automatic fire(input logic [31:0] pc, input logic [1:0] ib, cs, tl);
    dec_valid = 1; dec_ready = 1; dec_pc = pc;
    ibar_flag = ib; csr_flag = cs; tlb_flag = tl;
  endtask
  task automatic wait_setpc(input int lat);
    exp_t e;
    for (int i = 1; i <= lat; i++) begin
      step();
      if (i < lat) chk("early_set_pc", {31'b0, set_pc}, 0);
    end
    chk("set_pc", {31'b0, set_pc}, 1);
    chk("stall_redirect", {31'b0, fetch_stall}, 1);
    chk("sb_nonempty", {31'b0, q.size() != 0}, 1);
    if (q.size() != 0) begin
      e = q.pop_front();
      chk("pc_target", pc_target, e.pc);
      chk("cause_redirect", {30'b0, priv_cause}, {30'b0, e.c});
    end
    step();
    chk("set_pc_one_cycle", {31'b0, set_pc}, 0);
    chk("busy_after", {31'b0, busy}, 0);
    chk("cause_cleared", {30'b0, priv_cause}, 0);
  endtask
  initial begin
    step(); step();
    chk("rst_outs", {fetch_stall, flush_fetch, set_pc, busy, priv_cause}, 0);
    chk("rst_pc", pc_target, 0);
    rst = 0;
    // IBAR slot 0
    fire(32'h1C000100, 2'b01, 0, 0); q.push_back('{32'h1C000104, 2'b01});
    step();
    chk("t1_flush", {31'b0, flush_fetch}, 1);
    chk("t1_stall", {31'b0, fetch_stall}, 1);
    chk("t1_cause", {30'b0, priv_cause}, 1);
    step(); step();
    ibar_from_ex = 1;
    step();
    chk("t1_flush_off", {31'b0, flush_fetch}, 0);
    chk("t1_busy", {31'b0, busy}, 1);
    step(); step();
    chk("t1_cause_hold", {30'b0, priv_cause}, 1);
    icache_idle = 1; dcache_idle = 1;
    wait_setpc(3);
    // CSR slot 1, done pulses early are lost
    fire(32'h1C000200, 0, 2'b10, 0); q.push_back('{32'h1C000208, 2'b10});
    step();
    csr_done = 1;
    step();
    chk("t2_early_done", {31'b0, flush_fetch}, 1);
    chk("t2_cause", {30'b0, priv_cause}, 2);
    csr_from_ex = 1; csr_done = 1;
    step();
    for (int i = 0; i < 3; i++) begin
      step();
      chk("t2_waiting", {busy, flush_fetch, set_pc}, 3'b100);
    end
    csr_done = 1;
    wait_setpc(3);
    // slot 0 TLB + slot 1 IBAR, with stray pulses in WAIT_EX
    fire(32'h1C000300, 2'b10, 0, 2'b01); q.push_back('{32'h1C000304, 2'b01});
    step();
    tlb_from_ex = 1; csr_from_ex = 1;
    step();
    chk("t3_nonmatch", {31'b0, flush_fetch}, 1);
    ibar_from_ex = 1;
    step();
    wait_setpc(3);
    // wraparound
    fire(32'hFFFFFFFC, 0, 0, 2'b10); q.push_back('{32'h00000004, 2'b11});
    step();
    tlb_from_ex = 1;
    step();
    tlb_done = 1;
    wait_setpc(3);
    // flush in WAIT_TLB_OK
    fire(32'h1C000600, 0, 0, 2'b01);
    step();
    tlb_from_ex = 1;
    step();
    flush = 1;
    step();
    chk("t4_flushed", {busy, fetch_stall, set_pc, priv_cause}, 0);
    tlb_done = 1;
    step();
    step();
    chk("t4_no_effect", {busy, set_pc}, 0);
    // fire with flush, then fire while busy
    fire(32'h1C000700, 2'b01, 0, 0); flush = 1;
    step();
    chk("t5_flush_wins", {busy, priv_cause}, 0);
    fire(32'h1C000800, 2'b01, 0, 0); q.push_back('{32'h1C000804, 2'b01});
    step();
    fire(32'h1C000900, 0, 2'b01, 0);
    step();
    chk("t5_busy_pc", pc_target, 32'h1C000804);
    chk("t5_busy_cause", {30'b0, priv_cause}, 1);
    ibar_from_ex = 1;
    step();
    wait_setpc(3);
    // reset mid-SETTLE
    fire(32'h1C000A00, 2'b01, 0, 0);
    step();
    ibar_from_ex = 1;
    step();
    step();
    chk("t6_settle", {busy, set_pc}, 2'b10);
    rst = 1;
    step();
    chk("t6_rst_outs", {fetch_stall, flush_fetch, set_pc, busy, priv_cause}, 0);
    chk("t6_rst_pc", pc_target, 0);
    rst = 0;
    // zero-settle build redirects the cycle after tlb_done
    fire(32'h1C000B00, 0, 0, 2'b01); q.push_back('{32'h1C000B04, 2'b11});
    step();
    tlb_from_ex = 1;
    step();
    tlb_done = 1;
    step();
    chk("z_set_pc", {31'b0, s0_set}, 1);
    chk("z_pc", s0_pc, 32'h1C000B04);
    chk("z_cause", {30'b0, s0_cause}, 3);
    chk("z_ref_not_yet", {31'b0, set_pc}, 0);
    wait_setpc(2);
    chk("z_back_idle", {31'b0, s0_busy}, 0);
    chk("sb_empty", q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
